// File: rtl/cpu_pkg.sv
// Shared constants and types for the rv32i_mini_core datapath.
package cpu_pkg;

  typedef enum logic [2:0] {
    ADD = 3'd0,
    SUB = 3'd1,
    AND = 3'd2,
    OR  = 3'd3,
    XOR = 3'd4,
    SLL = 3'd5,
    SRL = 3'd6,
    SLT = 3'd7
  } alu_op_t;

  localparam logic [6:0]  OP_R           = 7'b0110011;
  localparam logic [6:0]  OP_I           = 7'b0010011;
  localparam logic [31:0] REG_RESET_BASE = 32'd3000;

endpackage

// File: rtl/rv32i_mini_core_alu.sv
// Combinational ALU for the mini core; shifts use b[4:0], SLT is signed.
module alu
  import cpu_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  alu_op_t     alu_op,
  output logic [31:0] result
);

  always_comb begin
    result = 32'd0;
    case (alu_op)
      ADD: result = a + b;
      SUB: result = a - b;
      AND: result = a & b;
      OR:  result = a | b;
      XOR: result = a ^ b;
      SLL: result = a << b[4:0];
      SRL: result = a >> b[4:0];
      SLT: result = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: result = 32'd0;
    endcase
  end

endmodule

// File: rtl/rv32i_mini_core.sv
// Single-cycle RV32I R/I-type ALU core with a 32-word instruction ROM.
// Optional macro CPU_TRACE_EN adds a simulation-only write trace.
module rv32i_mini_core
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] initial_instructions [32],
  output logic [31:0] pc_out_check,
  output logic [31:0] instruction_check,
  output logic [2:0]  alu_op_check,
  output logic [31:0] register_data_out1_check,
  output logic [31:0] register_data_out2_check,
  output logic [31:0] imm_ext_check,
  output logic        use_imm_check,
  output logic [31:0] b_input_check,
  output logic [31:0] alu_result_check,
  output logic [31:0] register_data_in_check,
  output logic        reg_write_check,
  output logic [31:0] register_check [32]
);

  logic [31:0] pc;
  logic [31:0] regs [32];
  logic [31:0] instruction;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [4:0]  rs1, rs2, rd;
  logic [31:0] imm_ext, rdata1, rdata2, b_input, alu_result;
  logic        use_imm, reg_write;
  alu_op_t     alu_op;

  assign instruction = initial_instructions[pc[6:2]];
  assign opcode      = instruction[6:0];
  assign funct3      = instruction[14:12];
  assign rd          = instruction[11:7];
  assign rs1         = instruction[19:15];
  assign rs2         = instruction[24:20];
  assign imm_ext     = {{20{instruction[31]}}, instruction[31:20]};

  // Unknown opcodes and the unsupported SLTU slot fall through as no-write ADDs.
  always_comb begin
    use_imm   = 1'b0;
    reg_write = 1'b0;
    alu_op    = ADD;
    if (opcode == OP_R || opcode == OP_I) begin
      use_imm   = (opcode == OP_I);
      reg_write = 1'b1;
      case (funct3)
        3'b000: alu_op = (opcode == OP_R && instruction[30]) ? SUB : ADD;
        3'b111: alu_op = AND;
        3'b110: alu_op = OR;
        3'b100: alu_op = XOR;
        3'b001: alu_op = SLL;
        3'b101: alu_op = SRL;
        3'b010: alu_op = SLT;
        default: begin
          alu_op    = ADD;
          reg_write = 1'b0;
        end
      endcase
    end
  end

  assign rdata1  = regs[rs1];
  assign rdata2  = regs[rs2];
  assign b_input = use_imm ? imm_ext : rdata2;

  alu u_alu (
    .a      (rdata1),
    .b      (b_input),
    .alu_op (alu_op),
    .result (alu_result)
  );

  // x0 is reset to zero and never written, so reads of it always return 0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc      <= 32'd0;
      regs[0] <= 32'd0;
      for (int i = 1; i < 32; i++) regs[i] <= REG_RESET_BASE + 32'(i);
    end else begin
      pc <= pc + 32'd4;
      if (reg_write && rd != 5'd0) regs[rd] <= alu_result;
    end
  end

`ifdef CPU_TRACE_EN
  always @(posedge clk) begin
    if (reset && reg_write)
      $display("[TRACE] pc=%08h inst=%08h rd=x%0d wdata=%08h", pc, instruction, rd, alu_result);
  end
`endif

  assign pc_out_check             = pc;
  assign instruction_check        = instruction;
  assign alu_op_check             = alu_op;
  assign register_data_out1_check = rdata1;
  assign register_data_out2_check = rdata2;
  assign imm_ext_check            = imm_ext;
  assign use_imm_check            = use_imm;
  assign b_input_check            = b_input;
  assign alu_result_check         = alu_result;
  assign register_data_in_check   = alu_result;
  assign reg_write_check          = reg_write;
  assign register_check           = regs;

endmodule

// File: tb/tb_rv32i_mini_core.sv
// Directed and randomized bench for rv32i_mini_core against an instruction-level model.
module tb_rv32i_mini_core;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] rom [32];
  logic [31:0] pc_out_check, instruction_check, out1, out2, imm_ext_check;
  logic [31:0] b_input_check, alu_result_check, register_data_in_check;
  logic [2:0]  alu_op_check;
  logic        use_imm_check, reg_write_check;
  logic [31:0] register_check [32];

  logic [31:0] ta, tb_b, tres;
  alu_op_t     top;

  int passCount = 0;
  int checkCount = 0;
  logic [31:0] mregs [32];
  logic [31:0] mpc;

  always #5 clk = ~clk;

  rv32i_mini_core dut (
    .clk                      (clk),
    .reset                    (reset),
    .initial_instructions     (rom),
    .pc_out_check             (pc_out_check),
    .instruction_check        (instruction_check),
    .alu_op_check             (alu_op_check),
    .register_data_out1_check (out1),
    .register_data_out2_check (out2),
    .imm_ext_check            (imm_ext_check),
    .use_imm_check            (use_imm_check),
    .b_input_check            (b_input_check),
    .alu_result_check         (alu_result_check),
    .register_data_in_check   (register_data_in_check),
    .reg_write_check          (reg_write_check),
    .register_check           (register_check)
  );

  alu u_alu_tb (.a(ta), .b(tb_b), .alu_op(top), .result(tres));

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    if (obs === exp) passCount++;
    else $display("[TB] FAIL %s: got %0d (0x%08h) expected %0d (0x%08h)", tag, obs, obs, exp, exp);
  endtask

  // Instruction-level reference: returns write enable, write data and whether the result is defined.
  task automatic modelExec(input logic [31:0] inst, output logic we, output logic [31:0] res,
                           output logic defined);
    logic [6:0]  opc;
    logic [31:0] a, b;
    opc = inst[6:0];
    a = mregs[inst[19:15]];
    b = (opc == OP_I) ? {{20{inst[31]}}, inst[31:20]} : mregs[inst[24:20]];
    we = 1'b1;
    defined = 1'b1;
    res = a + b;
    if (opc != OP_R && opc != OP_I) begin
      we = 1'b0;
    end else begin
      case (inst[14:12])
        3'd0: res = (opc == OP_R && inst[30]) ? a - b : a + b;
        3'd7: res = a & b;
        3'd6: res = a | b;
        3'd4: res = a ^ b;
        3'd1: res = a << b[4:0];
        3'd5: res = a >> b[4:0];
        3'd2: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
        default: begin we = 1'b0; defined = 1'b0; end
      endcase
    end
  endtask

  task automatic modelReset();
    mpc = 32'd0;
    mregs[0] = 32'd0;
    for (int i = 1; i < 32; i++) mregs[i] = 32'd3000 + 32'(i);
  endtask

  function automatic logic [31:0] randInst();
    int kind;
    logic [4:0] rd, rs1, rs2;
    logic [2:0] f3;
    kind = $urandom_range(0, 9);
    rd = 5'($urandom); rs1 = 5'($urandom); rs2 = 5'($urandom); f3 = 3'($urandom);
    if (kind <= 3) return {1'b0, 1'($urandom), 5'd0, rs2, rs1, f3, rd, OP_R};
    if (kind <= 7) return {12'($urandom), rs1, f3, rd, OP_I};
    if (kind == 8) return 32'd0;
    return {25'($urandom), 7'b0000011};
  endfunction

  // One random program cycle: combinational checks, edge, then state checks.
  task automatic applyStimulus(input int cyc);
    logic [31:0] inst, res;
    logic we, defined;
    inst = rom[mpc[6:2]];
    modelExec(inst, we, res, defined);
    checkOutput($sformatf("inst[%0d]", cyc), instruction_check, inst);
    checkOutput($sformatf("we[%0d]", cyc), 32'(reg_write_check), 32'(we));
    if (defined) checkOutput($sformatf("res[%0d]", cyc), alu_result_check, res);
    @(posedge clk); #1;
    if (we && inst[11:7] != 5'd0) mregs[inst[11:7]] = res;
    mpc = mpc + 32'd4;
    checkOutput($sformatf("pc[%0d]", cyc), pc_out_check, mpc);
    checkOutput($sformatf("rd[%0d]", cyc), register_check[inst[11:7]], mregs[inst[11:7]]);
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] aluExp [8];
    aluExp[0] = 6; aluExp[1] = 2; aluExp[2] = 0; aluExp[3] = 6;
    aluExp[4] = 6; aluExp[5] = 16; aluExp[6] = 1; aluExp[7] = 0;

    ta = 32'd4; tb_b = 32'd2;
    for (int i = 0; i < 8; i++) begin
      top = alu_op_t'(i);
      #1 checkOutput($sformatf("alu_op%0d", i), tres, aluExp[i]);
    end
    ta = 32'hFFFF_FFFF; tb_b = 32'd0; top = SLT;
    #1 checkOutput("alu_slt_neg", tres, 32'd1);

    for (int i = 0; i < 32; i++) rom[i] = 32'd0;
    rom[0] = 32'h005303B3;
    rom[1] = 32'h40848533;
    rom[2] = 32'h00160693;
    rom[3] = 32'h00508013;

    reset = 1'b0;
    #2;
    checkOutput("rst_pc", pc_out_check, 32'd0);
    checkOutput("rst_x6", register_check[6], 32'd3006);
    checkOutput("rst_x0", register_check[0], 32'd0);
    checkOutput("rst_inst", instruction_check, 32'h005303B3);

    @(negedge clk); reset = 1'b1; #1;
    checkOutput("add_op", 32'(alu_op_check), 32'(ADD));
    checkOutput("add_out1", out1, 32'd3006);
    checkOutput("add_out2", out2, 32'd3005);
    checkOutput("add_res", alu_result_check, 32'd6011);
    checkOutput("add_useimm", 32'(use_imm_check), 32'd0);
    @(posedge clk); #1;
    checkOutput("add_x7", register_check[7], 32'd6011);
    checkOutput("add_pc", pc_out_check, 32'd4);

    @(negedge clk);
    checkOutput("sub_op", 32'(alu_op_check), 32'(SUB));
    checkOutput("sub_out1", out1, 32'd3009);
    checkOutput("sub_out2", out2, 32'd3008);
    checkOutput("sub_res", alu_result_check, 32'd1);
    @(posedge clk); #1;
    checkOutput("sub_x10", register_check[10], 32'd1);

    @(negedge clk);
    checkOutput("addi_useimm", 32'(use_imm_check), 32'd1);
    checkOutput("addi_imm", imm_ext_check, 32'd1);
    checkOutput("addi_b", b_input_check, 32'd1);
    checkOutput("addi_res", alu_result_check, 32'd3013);
    checkOutput("addi_wdata", register_data_in_check, 32'd3013);
    @(posedge clk); #1;
    checkOutput("addi_x13", register_check[13], 32'd3013);

    @(negedge clk);
    checkOutput("x0_we", 32'(reg_write_check), 32'd1);
    @(posedge clk); #1;
    checkOutput("x0_zero", register_check[0], 32'd0);
    checkOutput("x0_pc", pc_out_check, 32'd16);

    #2 reset = 1'b0; #1;
    checkOutput("midrst_pc", pc_out_check, 32'd0);
    checkOutput("midrst_x7", register_check[7], 32'd3007);
    checkOutput("midrst_x13", register_check[13], 32'd3013 - 32'd0);

    for (int i = 0; i < 32; i++) rom[i] = randInst();
    modelReset();
    @(negedge clk); reset = 1'b1;
    for (int c = 0; c < 80; c++) applyStimulus(c);
    for (int i = 0; i < 32; i++)
      checkOutput($sformatf("final_x%0d", i), register_check[i], mregs[i]);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
